w5300_bus_arbiter: RTL and testbench
====================================

# w5300_bus_arbiter

Sequences every access to the W5300 16-bit direct-mode parallel bus and shares that bus between up to N_REQ internal requesters, for example the init sequencer, the socket TX path and the socket RX path. Each requester posts one register or FIFO access (address, read/write, write data). The block arbitrates round-robin and drives CS/RD/WR with the configured strobe widths. It returns read data together with a per-requester completion pulse. It sits between the W5300 register clients and the chip pins.

## Interface
- N_REQ, 3, number of requesters (2..8)
- RD_LOW_CYC, 7, clk cycles rd_n is held low (≥1)
- WR_LOW_CYC, 5, clk cycles wr_n is held low (≥1)
- RECOVERY_CYC, 3, clk cycles cs_n is held high after each access (≥1)
- clk  in  1  system clock, 100 MHz (common::CLK_REF)
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  request valid, one bit per requester
- req_op  in  N_REQ  per requester W5300::AddrOperation: 0 = WR, 1 = RD
- req_addr  in  N_REQ×10  per requester word address
- req_wdata  in  N_REQ×16  per requester write data
- req_lock  in  N_REQ  burst lock (functional only with W5300_ARB_LOCK_EN)
- done  out  N_REQ  one-cycle completion pulse to the served requester
- rdata  out  16  read data, valid in the cycle done is high
- busy  out  1  high whenever state ≠ IDLE
- w5300_addr  out  10  chip address
- w5300_data_o  out  16  chip write data
- w5300_data_oe  out  1  tristate enable for the data bus
- w5300_data_i  in  16  chip read data
- w5300_cs_n / w5300_rd_n / w5300_wr_n  out  1 each  chip strobes

## Operation
- States: IDLE → SETUP → STROBE → HOLD → RECOVER → IDLE.
- **IDLE:** if any req bit is high, pick a winner round-robin, starting the search at last_grant+1 and wrapping modulo N_REQ. Latch the winner's op, addr and wdata into internal registers. Go to SETUP.
- **SETUP (1 cycle):** cs_n=0, addr driven. For a write, data_oe=1 and data_o is driven.
- **STROBE:** the rd_n or wr_n strobe is low for RD_LOW_CYC or WR_LOW_CYC cycles, counted by a down-counter. For a read, rdata is registered from w5300_data_i on the final STROBE cycle's clock edge.
- **HOLD (1 cycle):** strobe high, cs_n still low, write data still driven. done[winner]=1 in this cycle. last_grant is updated to the winner.
- **RECOVER:** cs_n=1, data_oe=0, for RECOVERY_CYC cycles.
- Requesters hold req, req_op, req_addr and req_wdata stable until their done pulse. They deassert req in the cycle after done unless they have another access.
- A req bit that drops while not granted is simply skipped. A req bit that drops after grant has no effect on the access in flight.
- rdata holds its value until the next read completes. It is not cleared after a write.

## Timing
- Reset values, applied immediately and asynchronously: cs_n=rd_n=wr_n=1, data_oe=0, addr=0, data_o=0, rdata=0, done=0, busy=0, state=IDLE, last_grant=N_REQ-1 (so requester 0 has first priority).
- Reset asserted mid-access: the strobes release at once. No done pulse is issued. The requester re-requests after reset.
- Write latency, from req seen in IDLE to done: 1 (IDLE) + 1 (SETUP) + WR_LOW_CYC + 1 (HOLD) = 8 cycles with defaults.
- Read latency: 10 cycles with defaults.
- Bus occupancy per access, from arbitration to the next IDLE: 3 + LOW_CYC + RECOVERY_CYC.
- cs_n low width: 2 + LOW_CYC cycles. Address and write data are stable from SETUP through HOLD inclusive.
- Simultaneous requests: served strictly in rotation. A requester that just completed goes last unless it is locked.

## Configuration
- Macro: **W5300_ARB_LOCK_EN**.
- **Defined:** if req_lock[winner]=1 at HOLD and req[winner] is still high in the next IDLE, the same requester wins again. This serves back-to-back Sn_TX_FIFOR/Sn_RX_FIFOR bursts without interleaving.
- **Undefined:** req_lock is ignored (port kept, left unconnected) and arbitration is pure round-robin after every access.

## Structure
- In package W5300:
  - the BusState enum: IDLE, SETUP, STROBE, HOLD, RECOVER;
  - the reuse of AddrOperation for req_op.
- Sub-module **rr_arbiter**:
  - inputs: req[N], last_grant;
  - outputs: grant_valid and grant_idx;
  - purely combinational, parameterised by N.
- The state machine, down-counter and latched-access registers live in w5300_bus_arbiter.

## Test plan
- **Single write:** req0 WR addr 0x200, data 0x0002.
  - wr_n low exactly 5 cycles, cs_n low 7 cycles.
  - data_o=0x0002 and addr=0x200 stable throughout.
  - done[0] 8 cycles after req; then 3 cycles of cs_n high.
- **Single read:** req1 RD addr 0x0FE, w5300_data_i=0x5300.
  - rd_n low 7 cycles, data_oe=0 throughout.
  - rdata=0x5300 while done[1]=1.
- **Contention:** req[2:0]=3'b111 held continuously.
  - Completion order 0,1,2,0,1,2.
  - Each access is separated by ≥3 cycles of cs_n high.
- **Reset mid-STROBE:** rst_n low during the 3rd wr_n-low cycle.
  - cs_n, wr_n return to 1 in the same cycle, no done pulse.
  - After release, requester 0 is served first.
- **Lock (macro defined):** req0 with req_lock=1 for 4 writes to 0x22E, req1 pending.
  - 4 consecutive done[0] pulses, then done[1].
  - With the macro undefined the order is 0,1,0,0,0.
- **Dropped request:** req1 pulses high for 1 cycle while req0 is in flight.
  - req1 is never granted; no done[1]; busy returns to 0.

Source files
------------

// File: rtl/w5300_bus_arbiter_pkg.sv
// Shared types for the W5300 direct-mode bus arbiter: access operation and bus sequencer states.
package W5300;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } AddrOperation;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } BusState;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/w5300_bus_arbiter_if.sv
// Requester-side access ports plus W5300 chip pins; master is the arbiter, slave the requesters/chip.
interface w5300_bus_arbiter_if #(
  parameter int N_REQ = 3
) ();
  import W5300::*;

  logic [N_REQ-1:0]             req;
  AddrOperation [N_REQ-1:0]     req_op;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]             req_lock;
  logic [N_REQ-1:0]             done;
  logic [DATA_W-1:0]            rdata;
  logic                         busy;

  logic [ADDR_W-1:0]            w5300_addr;
  logic [DATA_W-1:0]            w5300_data_o;
  logic                         w5300_data_oe;
  logic [DATA_W-1:0]            w5300_data_i;
  logic                         w5300_cs_n;
  logic                         w5300_rd_n;
  logic                         w5300_wr_n;

  modport master (
    input  req, req_op, req_addr, req_wdata, req_lock, w5300_data_i,
    output done, rdata, busy, w5300_addr, w5300_data_o, w5300_data_oe,
           w5300_cs_n, w5300_rd_n, w5300_wr_n
  );

  modport slave (
    output req, req_op, req_addr, req_wdata, req_lock, w5300_data_i,
    input  done, rdata, busy, w5300_addr, w5300_data_o, w5300_data_oe,
           w5300_cs_n, w5300_rd_n, w5300_wr_n
  );

endinterface

// File: rtl/w5300_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts at last_grant+1 and wraps modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] lg, input int off);
    return IW'((int'(lg) + off) % N);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[wrapIdx(last_grant, i)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrapIdx(last_grant, i);
      end
    end
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// W5300 16-bit direct-mode bus sequencer shared round-robin between N_REQ requesters.
// Define W5300_ARB_LOCK_EN to let a locked requester keep the bus for back-to-back accesses.
module w5300_bus_arbiter
  import W5300::*;
#(
  parameter int N_REQ        = 3,
  parameter int RD_LOW_CYC   = 7,
  parameter int WR_LOW_CYC   = 5,
  parameter int RECOVERY_CYC = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  w5300_bus_arbiter_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(maxOf(maxOf(RD_LOW_CYC, WR_LOW_CYC), RECOVERY_CYC) + 1);
  localparam logic [CW-1:0] RD_CNT  = CW'(RD_LOW_CYC);
  localparam logic [CW-1:0] WR_CNT  = CW'(WR_LOW_CYC);
  localparam logic [CW-1:0] REC_CNT = CW'(RECOVERY_CYC);

  BusState      state;
  AddrOperation curOp;
  logic [IW-1:0] lastGrant, curIdx;
  logic [CW-1:0] cnt;
  logic          grantValid, winValid;
  logic [IW-1:0] grantIdx, winIdx;

  rr_arbiter #(.N(N_REQ)) uArb (
    .req        (bus.req),
    .last_grant (lastGrant),
    .grant_valid(grantValid),
    .grant_idx  (grantIdx)
  );

`ifdef W5300_ARB_LOCK_EN
  logic lockPend;

  // A requester that held its lock through HOLD re-wins if it is still requesting.
  always_comb begin
    winValid = grantValid;
    winIdx   = grantIdx;
    if (lockPend && bus.req[curIdx]) begin
      winValid = 1'b1;
      winIdx   = curIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lockPend <= 1'b0;
    else if (state == HOLD) lockPend <= bus.req_lock[curIdx];
  end
`else
  assign winValid = grantValid;
  assign winIdx   = grantIdx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      curOp             <= OP_WR;
      curIdx            <= '0;
      lastGrant         <= IW'(N_REQ - 1);
      cnt               <= '0;
      bus.done          <= '0;
      bus.rdata         <= '0;
      bus.busy          <= 1'b0;
      bus.w5300_addr    <= '0;
      bus.w5300_data_o  <= '0;
      bus.w5300_data_oe <= 1'b0;
      bus.w5300_cs_n    <= 1'b1;
      bus.w5300_rd_n    <= 1'b1;
      bus.w5300_wr_n    <= 1'b1;
    end else begin
      bus.done <= '0;
      case (state)
        IDLE: begin
          if (winValid) begin
            curIdx            <= winIdx;
            curOp             <= bus.req_op[winIdx];
            bus.w5300_addr    <= bus.req_addr[winIdx];
            bus.w5300_data_o  <= bus.req_wdata[winIdx];
            bus.w5300_data_oe <= (bus.req_op[winIdx] == OP_WR);
            bus.w5300_cs_n    <= 1'b0;
            bus.busy          <= 1'b1;
            state             <= SETUP;
          end
        end
        SETUP: begin
          if (curOp == OP_RD) begin
            bus.w5300_rd_n <= 1'b0;
            cnt            <= RD_CNT;
          end else begin
            bus.w5300_wr_n <= 1'b0;
            cnt            <= WR_CNT;
          end
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == CW'(1)) begin
            bus.w5300_rd_n <= 1'b1;
            bus.w5300_wr_n <= 1'b1;
            if (curOp == OP_RD) bus.rdata <= bus.w5300_data_i;
            bus.done[curIdx] <= 1'b1;
            state            <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          bus.w5300_cs_n    <= 1'b1;
          bus.w5300_data_oe <= 1'b0;
          lastGrant         <= curIdx;
          cnt               <= REC_CNT;
          state             <= RECOVER;
        end
        RECOVER: begin
          if (cnt == CW'(1)) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Bench for w5300_bus_arbiter: vector table of single accesses, scoreboard-checked completions,
// pin-level strobe timing monitor, and hand sequences for reset, contention, lock and dropped requests.
module tb_w5300_bus_arbiter;
  import W5300::*;

  localparam int N = 3, RDC = 7, WRC = 5, RECC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  w5300_bus_arbiter_if #(.N_REQ(N)) bus ();

  w5300_bus_arbiter #(
    .N_REQ(N), .RD_LOW_CYC(RDC), .WR_LOW_CYC(WRC), .RECOVERY_CYC(RECC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int           idx;
    AddrOperation op;
    logic [9:0]   addr;
    logic [15:0]  wdata;
    logic [15:0]  din;
  } exp_t;

  typedef struct {
    int           idx;
    AddrOperation op;
    logic [9:0]   addr;
    logic [15:0]  wdata;
    logic [15:0]  din;
    int           lat;
  } vec_t;

  exp_t sb[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin monitor + scoreboard consumer
  bit csPrev, wrPrev, rdPrev, haveGap, sawRd, unstable, oeBad, capOe;
  int csLow, wrLow, rdLow, gap;
  logic [9:0]  capAddr;
  logic [15:0] capData, lastRd;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      csPrev = 1; wrPrev = 1; rdPrev = 1; haveGap = 0; sawRd = 0; unstable = 0; oeBad = 0;
      csLow = 0; wrLow = 0; rdLow = 0; gap = 0; lastRd = '0;
      sb.delete();
    end else begin
      if (!bus.w5300_cs_n) begin
        if (csPrev) begin
          csLow = 0; capAddr = bus.w5300_addr; capData = bus.w5300_data_o; capOe = bus.w5300_data_oe;
          unstable = 0; oeBad = 0; sawRd = 0;
          if (haveGap) chk("cs_high_gap_ge_recovery", 32'(gap >= RECC), 32'd1);
        end
        csLow++;
        if (bus.w5300_addr !== capAddr || (capOe && bus.w5300_data_o !== capData)) unstable = 1;
      end else begin
        if (!csPrev) begin
          chk("cs_low_width", 32'(csLow), 32'(2 + (sawRd ? RDC : WRC)));
          chk("addr_data_stable", 32'(unstable), 32'd0);
          if (sawRd) chk("oe_low_during_read", 32'(oeBad), 32'd0);
          haveGap = 1; gap = 0;
        end
        gap++;
      end
      if (!bus.w5300_wr_n) wrLow++;
      else if (!wrPrev) begin chk("wr_low_width", 32'(wrLow), 32'(WRC)); wrLow = 0; end
      if (!bus.w5300_rd_n) begin
        rdLow++; sawRd = 1;
        if (bus.w5300_data_oe) oeBad = 1;
      end else if (!rdPrev) begin chk("rd_low_width", 32'(rdLow), 32'(RDC)); rdLow = 0; end
      if (bus.done != '0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %b expected none", bus.done);
        end else begin
          e = sb.pop_front();
          chk("done_idx", 32'(bus.done), 32'(1 << e.idx));
          chk("done_addr", 32'(bus.w5300_addr), 32'(e.addr));
          if (e.op == OP_RD) begin
            chk("rdata", 32'(bus.rdata), 32'(e.din));
            lastRd = e.din;
          end else begin
            chk("wdata", 32'(bus.w5300_data_o), 32'(e.wdata));
            chk("oe_write", 32'(bus.w5300_data_oe), 32'd1);
            chk("rdata_hold", 32'(bus.rdata), 32'(lastRd));
          end
        end
      end
      csPrev = bus.w5300_cs_n; wrPrev = bus.w5300_wr_n; rdPrev = bus.w5300_rd_n;
    end
  end

  task automatic pushExp(input int idx);
    sb.push_back('{idx, bus.req_op[idx], bus.req_addr[idx], bus.req_wdata[idx], bus.w5300_data_i});
  endtask

  task automatic setReq(input int idx, input AddrOperation op, input logic [9:0] a, input logic [15:0] d);
    bus.req_op[idx] = op; bus.req_addr[idx] = a; bus.req_wdata[idx] = d;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic doAccess(input vec_t v);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    setReq(v.idx, v.op, v.addr, v.wdata);
    bus.w5300_data_i = v.din;
    pushExp(v.idx);
    bus.req[v.idx] = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (n == 2) chk("busy_active", 32'(bus.busy), 32'd1);
      if (bus.done[v.idx]) got = 1;
    end
    chk("latency", 32'(n), 32'(v.lat));
    @(posedge clk); #1 bus.req[v.idx] = 1'b0;
    waitIdle();
  endtask

  // Requesters hold req until their count of done pulses is reached, then drop it.
  task automatic runMulti(input int r0, input int r1, input int r2, input int budget);
    int rem[N];
    bit drop[N];
    int n = 0;
    int left;
    rem = '{r0, r1, r2};
    left = r0 + r1 + r2;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (rem[i] > 0) bus.req[i] = 1'b1;
    while (left > 0 && n < budget) begin
      @(negedge clk); n++;
      for (int i = 0; i < N; i++) begin
        drop[i] = 0;
        if (bus.done[i] && rem[i] > 0) begin
          rem[i]--; left--;
          if (rem[i] == 0) drop[i] = 1;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (drop[i]) bus.req[i] = 1'b0;
    end
    chk("multi_all_done", 32'(left), 32'd0);
    bus.req = '0;
    waitIdle();
  endtask

  vec_t vecs[6];

  initial begin
    int n, lowCnt, d0, d1;
    vecs[0] = '{0, OP_WR, 10'h200, 16'h0002, 16'h0000, 8};
    vecs[1] = '{1, OP_RD, 10'h0FE, 16'h0000, 16'h5300, 10};
    vecs[2] = '{2, OP_WR, 10'h3FF, 16'hFFFF, 16'h1234, 8};
    vecs[3] = '{0, OP_RD, 10'h000, 16'hBEEF, 16'hA5A5, 10};
    vecs[4] = '{2, OP_RD, 10'h22E, 16'h0000, 16'h0000, 10};
    vecs[5] = '{1, OP_WR, 10'h155, 16'h8001, 16'hFFFF, 8};

    bus.req = '0; bus.req_lock = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.w5300_data_i = '0;
    for (int i = 0; i < N; i++) bus.req_op[i] = OP_WR;

    #12;
    chk("rst_cs_n", 32'(bus.w5300_cs_n), 32'd1);
    chk("rst_rd_n", 32'(bus.w5300_rd_n), 32'd1);
    chk("rst_wr_n", 32'(bus.w5300_wr_n), 32'd1);
    chk("rst_oe", 32'(bus.w5300_data_oe), 32'd0);
    chk("rst_addr", 32'(bus.w5300_addr), 32'd0);
    chk("rst_data_o", 32'(bus.w5300_data_o), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) doAccess(vecs[i]);

    // Reset in the 3rd wr_n-low cycle
    @(posedge clk); #1;
    setReq(0, OP_WR, 10'h1A0, 16'h7777);
    bus.req[0] = 1'b1;
    n = 0; lowCnt = 0;
    while (lowCnt < 3 && n < 50) begin
      @(negedge clk); n++;
      if (!bus.w5300_wr_n) lowCnt++;
    end
    chk("reached_strobe", 32'(lowCnt), 32'd3);
    #2 rst_n = 1'b0; bus.req = '0;
    #1;
    chk("midrst_cs_n", 32'(bus.w5300_cs_n), 32'd1);
    chk("midrst_wr_n", 32'(bus.w5300_wr_n), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    setReq(0, OP_WR, 10'h010, 16'h0101);
    setReq(2, OP_RD, 10'h020, 16'h0000);
    bus.w5300_data_i = 16'hC0DE;
    pushExp(0); pushExp(2);
    runMulti(1, 0, 1, 100);

    // Contention: all three held, strict rotation
    setReq(0, OP_WR, 10'h100, 16'h1111);
    setReq(1, OP_RD, 10'h101, 16'h0000);
    setReq(2, OP_WR, 10'h102, 16'h3333);
    bus.w5300_data_i = 16'h2222;
    for (int k = 0; k < 2; k++) begin pushExp(0); pushExp(1); pushExp(2); end
    runMulti(2, 2, 2, 200);

    // Burst lock on requester 0 with requester 1 pending
    setReq(0, OP_WR, 10'h22E, 16'h0F0F);
    setReq(1, OP_WR, 10'h22F, 16'hF0F0);
    bus.req_lock[0] = 1'b1;
`ifdef W5300_ARB_LOCK_EN
    pushExp(0); pushExp(0); pushExp(0); pushExp(0); pushExp(1);
`else
    pushExp(0); pushExp(1); pushExp(0); pushExp(0); pushExp(0);
`endif
    runMulti(4, 1, 0, 300);
    bus.req_lock = '0;

    // Requester 1 pulses for one cycle while requester 0 is in flight
    setReq(0, OP_WR, 10'h300, 16'h4242);
    setReq(1, OP_RD, 10'h301, 16'h0000);
    pushExp(0);
    @(posedge clk); #1 bus.req[0] = 1'b1;
    @(posedge clk); #1 bus.req[1] = 1'b1;
    @(posedge clk); #1 bus.req[1] = 1'b0;
    n = 0; d0 = 0; d1 = 0;
    while (n < 60 && !(d0 > 0 && !bus.busy)) begin
      @(negedge clk); n++;
      if (bus.done[0]) begin d0++; bus.req[0] = 1'b0; end
      if (bus.done[1]) d1++;
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.done[1]) d1++;
    end
    chk("drop_done0", 32'(d0), 32'd1);
    chk("drop_no_done1", 32'(d1), 32'd0);
    chk("drop_busy_idle", 32'(bus.busy), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
